// File: rtl/counter_updown_sched.sv
`default_nettype none
// ============================================================================
// Module   : counter_updown_sched
// Brief    : Round-robin scheduler sharing one up/down counter between two
//            requesters; loads, runs to terminal count, repeats, pulses done.
//            Optional load readback check: COUNTER_UPDOWN_SCHED_LOADCHK_EN.
// Revision : 1.0 - initial release
// ============================================================================
module counter_updown_sched #(
  parameter int WIDTH = 8,
  parameter int REP_W = 4
) (
  input  logic                 clk,
  input  logic                 reset_n,
  input  logic [1:0]           req_valid,
  output logic [1:0]           req_ready,
  input  logic [2*WIDTH-1:0]   req_start,
  input  logic [1:0]           req_dir,
  input  logic [2*REP_W-1:0]   req_reps,
  input  logic                 pause,
  output logic                 cnt_load,
  output logic                 cnt_up_down,
  output logic                 cnt_count_en,
  output logic [WIDTH-1:0]     cnt_data,
  input  logic [WIDTH-1:0]     cnt_count,
  input  logic                 cnt_carry,
  output logic                 busy,
  output logic                 owner,
  output logic [1:0]           done,
  output logic                 err
);

  localparam logic [REP_W-1:0] C_REP_ONE = {{(REP_W-1){1'b0}}, 1'b1};

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_LOAD  = 3'd1,
    S_RUN   = 3'd2,
    S_DONE  = 3'd3
`ifdef COUNTER_UPDOWN_SCHED_LOADCHK_EN
    , S_CHECK = 3'd4
`endif
  } state_t;

  state_t           r_state;
  state_t           w_next;
  logic [WIDTH-1:0] r_start;
  logic             r_dir;
  logic [REP_W-1:0] r_reps_left;
  logic             r_owner;
  logic             r_last_grant;
  logic             w_win;
  logic             w_accept;
  logic             w_terminal;
  logic             w_err_set;

  // On contention the requester not granted last time wins.
  assign w_win      = (req_valid == 2'b11) ? ~r_last_grant : req_valid[1];
  assign w_accept   = (r_state == S_IDLE) && (|req_valid);
  assign w_terminal = cnt_carry && !pause;

  always_comb begin
    w_next       = r_state;
    req_ready    = 2'b00;
    cnt_count_en = 1'b0;
    w_err_set    = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (|req_valid) begin
          req_ready = w_win ? 2'b10 : 2'b01;
          w_next    = S_LOAD;
        end
      end
      S_LOAD: begin
`ifdef COUNTER_UPDOWN_SCHED_LOADCHK_EN
        w_next = S_CHECK;
`else
        w_next = S_RUN;
`endif
      end
`ifdef COUNTER_UPDOWN_SCHED_LOADCHK_EN
      S_CHECK: begin
        if (cnt_count == r_start) begin
          w_next = S_RUN;
        end else begin
          w_err_set = 1'b1;
          w_next    = S_IDLE;
        end
      end
`endif
      S_RUN: begin
        // Enable drops combinationally on carry so the counter never wraps.
        cnt_count_en = !cnt_carry && !pause;
        if (w_terminal) begin
          w_next = (r_reps_left == '0) ? S_DONE : S_LOAD;
        end
      end
      S_DONE: begin
        w_next = S_IDLE;
      end
      default: begin
        w_next = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_start      <= '0;
      r_dir        <= 1'b0;
      r_reps_left  <= '0;
      r_owner      <= 1'b0;
      r_last_grant <= 1'b1;
    end else if (w_accept) begin
      r_start      <= w_win ? req_start[2*WIDTH-1:WIDTH] : req_start[WIDTH-1:0];
      r_dir        <= req_dir[w_win];
      r_reps_left  <= w_win ? req_reps[2*REP_W-1:REP_W] : req_reps[REP_W-1:0];
      r_owner      <= w_win;
      r_last_grant <= w_win;
    end else if ((r_state == S_RUN) && w_terminal && (r_reps_left != '0)) begin
      r_reps_left  <= r_reps_left - C_REP_ONE;
    end
  end

`ifdef COUNTER_UPDOWN_SCHED_LOADCHK_EN
  logic r_err;

  // Registered so err stays free of any input-to-output path.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_err <= 1'b0;
    end else begin
      r_err <= w_err_set;
    end
  end

  assign err = r_err;
`else
  logic w_unused;

  assign w_unused = (^cnt_count) ^ w_err_set;
  assign err      = 1'b0;
`endif

  assign cnt_load    = (r_state == S_LOAD);
  assign cnt_up_down = r_dir;
  assign cnt_data    = r_start;
  assign busy        = (r_state != S_IDLE);
  assign owner       = r_owner;
  assign done        = (r_state == S_DONE) ? (r_owner ? 2'b10 : 2'b01) : 2'b00;

endmodule
`default_nettype wire
